mmc1_regs: RTL and testbench



---
 rtl/mmc1_regs_if.sv | 25 ++
 rtl/mmc1_regs.sv | 115 +++++++++++
 tb/tb_mmc1_regs.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmc1_regs_if.sv
// CPU/PPU bus bundle seen by the MMC1 mapper.
// master drives address/data/strobes, slave (the mapper) samples them.
interface mmc1_regs_if;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_i;
  logic        cpu_rw;
  logic        romsel;
  logic [13:0] ppu_addr;

  modport master (
    output cpu_addr,
    output cpu_data_i,
    output cpu_rw,
    output romsel,
    output ppu_addr
  );

  modport slave (
    input cpu_addr,
    input cpu_data_i,
    input cpu_rw,
    input romsel,
    input ppu_addr
  );
endinterface

// File: rtl/mmc1_regs.sv
// MMC1 serial-port register file with PRG/CHR/mirroring translation.
// Ports: clk_cpu, rst, bus (slave), prg_addr, prg_ram_ce, chr_addr, ciram_a10, ctrl, chr0, chr1, prg.
module mmc1_regs #(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 13
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  mmc1_regs_if.slave               bus,
  output logic [PRG_ROM_DEPTH-1:0] prg_addr,
  output logic                     prg_ram_ce,
  output logic [CHR_ROM_DEPTH-1:0] chr_addr,
  output logic                     ciram_a10,
  output logic [4:0]               ctrl,
  output logic [4:0]               chr0,
  output logic [4:0]               chr1,
  output logic [4:0]               prg
);

  logic       wr;
  logic       wr_q;
  logic       acc;
  logic [4:0] shift;
  logic [2:0] cnt;
  logic [4:0] val;

  // Only the first cycle of a back-to-back write burst (RMW) counts.
  assign wr  = !bus.cpu_rw && !bus.romsel;
  assign acc = wr && !wr_q;
  assign val = {bus.cpu_data_i[0], shift[4:1]};

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      wr_q  <= 1'b0;
      shift <= 5'd0;
      cnt   <= 3'd0;
      ctrl  <= 5'b01100;
      chr0  <= 5'd0;
      chr1  <= 5'd0;
      prg   <= 5'd0;
    end else begin
      wr_q <= wr;
      if (acc) begin
        // bit7 is checked first so it beats a would-be fifth write
        if (bus.cpu_data_i[7]) begin
          shift <= 5'd0;
          cnt   <= 3'd0;
          ctrl  <= ctrl | 5'b01100;
        end else if (cnt != 3'd4) begin
          shift <= val;
          cnt   <= cnt + 3'd1;
        end else begin
          shift <= 5'd0;
          cnt   <= 3'd0;
          unique case (bus.cpu_addr[14:13])
            2'b00:   ctrl <= val;
            2'b01:   chr0 <= val;
            2'b10:   chr1 <= val;
            default: prg  <= val;
          endcase
        end
      end
    end
  end

  logic       a14;
  logic [3:0] bank;
  logic [17:0] prg_full;
  logic [16:0] chr_full;

  assign a14 = bus.cpu_addr[14];

  always_comb begin
    bank = 4'h0;
    unique case (1'b1)
      !ctrl[3]:
        bank = {prg[3:1], a14};
      ctrl[3:2] == 2'b10:
        bank = a14 ? prg[3:0] : 4'h0;
      default:
        bank = a14 ? 4'hF : prg[3:0];
    endcase
  end

  always_comb begin
    chr_full = 17'd0;
    if (ctrl[4])
      chr_full = {bus.ppu_addr[12] ? chr1 : chr0,
                  bus.ppu_addr[11:0]};
    else
      chr_full = {chr0[4:1], bus.ppu_addr[12:0]};
  end

  always_comb begin
    ciram_a10 = 1'b0;
    unique case (ctrl[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = bus.ppu_addr[10];
      default: ciram_a10 = bus.ppu_addr[11];
    endcase
  end

  // Bank index is simply truncated to the fitted ROM size.
  assign prg_full   = {bank, bus.cpu_addr[13:0]};
  assign prg_addr   = prg_full[PRG_ROM_DEPTH-1:0];
  assign chr_addr   = chr_full[CHR_ROM_DEPTH-1:0];
  assign prg_ram_ce = bus.romsel && (bus.cpu_addr[14:13] == 2'b11)
                      && !prg[4];

  logic unused_bits;
  assign unused_bits = ^{prg_full, chr_full, bus.ppu_addr[13],
                         bus.cpu_data_i[6:1]};

endmodule

// File: tb/tb_mmc1_regs.sv
// Directed self-checking bench for mmc1_regs.
// Drives the CPU/PPU bus through the interface and checks registers and mappings.
module tb_mmc1_regs;
  logic        clk_cpu;
  logic        rst;
  logic [16:0] prg_addr;
  logic        prg_ram_ce;
  logic [12:0] chr_addr;
  logic        ciram_a10;
  logic [4:0]  ctrl, chr0, chr1, prg;
  int          pass_cnt;
  int          total_cnt;

  mmc1_regs_if bus ();

  mmc1_regs #(.PRG_ROM_DEPTH(17), .CHR_ROM_DEPTH(13)) dut (
    .clk_cpu   (clk_cpu),
    .rst       (rst),
    .bus       (bus.slave),
    .prg_addr  (prg_addr),
    .prg_ram_ce(prg_ram_ce),
    .chr_addr  (chr_addr),
    .ciram_a10 (ciram_a10),
    .ctrl      (ctrl),
    .chr0      (chr0),
    .chr1      (chr1),
    .prg       (prg)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic idle();
    bus.cpu_rw     = 1'b1;
    bus.romsel     = 1'b1;
    bus.cpu_data_i = 8'h00;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d,
                    input logic rom = 1'b0);
    bus.cpu_addr   = a;
    bus.cpu_data_i = d;
    bus.cpu_rw     = 1'b0;
    bus.romsel     = rom;
    tick();
    idle();
    tick();
  endtask

  task automatic wr5(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'd0, v[i]});
  endtask

  task automatic rd(input logic [14:0] a, input logic rom);
    bus.cpu_addr = a;
    bus.cpu_rw   = 1'b1;
    bus.romsel   = rom;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.cpu_addr = 15'h0;
    bus.ppu_addr = 14'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (ctrl !== 5'h0C) $display("FAIL rst_ctrl got %h exp %h", ctrl, 5'h0C);
    else pass_cnt++;
    total_cnt++;
    if (prg !== 5'h00 || chr0 !== 5'h00 || chr1 !== 5'h00)
      $display("FAIL rst_banks got %h/%h/%h exp 00/00/00", prg, chr0, chr1);
    else pass_cnt++;
    rd(15'h4000, 1'b0);
    total_cnt++;
    if (prg_addr !== 17'h1C000) $display("FAIL rst_c000 got %h exp %h", prg_addr, 17'h1C000);
    else pass_cnt++;
    rd(15'h0000, 1'b0);
    total_cnt++;
    if (prg_addr !== 17'h00000) $display("FAIL rst_8000 got %h exp %h", prg_addr, 17'h0);
    else pass_cnt++;
    bus.ppu_addr = 14'h2C00;
    #1;
    total_cnt++;
    if (ciram_a10 !== 1'b0) $display("FAIL rst_ciram got %b exp 0", ciram_a10);
    else pass_cnt++;
    rd(15'h6000, 1'b1);
    total_cnt++;
    if (prg_ram_ce !== 1'b1) $display("FAIL rst_ramce got %b exp 1", prg_ram_ce);
    else pass_cnt++;
    rd(15'h6000, 1'b0);
    total_cnt++;
    if (prg_ram_ce !== 1'b0) $display("FAIL ramce_romsel got %b exp 0", prg_ram_ce);
    else pass_cnt++;
    bus.ppu_addr = 14'h1ABC;
    #1;
    total_cnt++;
    if (chr_addr !== 13'h1ABC) $display("FAIL chr_mode0 got %h exp %h", chr_addr, 13'h1ABC);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_prg_load();
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h00);
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h00);
    total_cnt++;
    if (prg !== 5'h00) $display("FAIL prg_early got %h exp %h", prg, 5'h00);
    else pass_cnt++;
    wr(15'h6000, 8'h00);
    total_cnt++;
    if (prg !== 5'h05) $display("FAIL prg_load got %h exp %h", prg, 5'h05);
    else pass_cnt++;
    rd(15'h0000, 1'b0);
    total_cnt++;
    if (prg_addr !== 17'h14000) $display("FAIL prg_8000 got %h exp %h", prg_addr, 17'h14000);
    else pass_cnt++;
    rd(15'h4123, 1'b0);
    total_cnt++;
    if (prg_addr !== 17'h1C123) $display("FAIL prg_c123 got %h exp %h", prg_addr, 17'h1C123);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_mirroring();
    wr5(15'h0000, 5'b00011);
    bus.ppu_addr = 14'h2800;
    #1;
    total_cnt++;
    if (ciram_a10 !== 1'b1) $display("FAIL mir_h_2800 got %b exp 1", ciram_a10);
    else pass_cnt++;
    bus.ppu_addr = 14'h2400;
    #1;
    total_cnt++;
    if (ciram_a10 !== 1'b0) $display("FAIL mir_h_2400 got %b exp 0", ciram_a10);
    else pass_cnt++;
    wr5(15'h0000, 5'b00001);
    total_cnt++;
    if (ciram_a10 !== 1'b1) $display("FAIL mir_one got %b exp 1", ciram_a10);
    else pass_cnt++;
    wr5(15'h0000, 5'b00010);
    total_cnt++;
    if (ctrl !== 5'h02) $display("FAIL ctrl_02 got %h exp %h", ctrl, 5'h02);
    else pass_cnt++;
    bus.ppu_addr = 14'h2400;
    #1;
    total_cnt++;
    if (ciram_a10 !== 1'b1) $display("FAIL mir_v_2400 got %b exp 1", ciram_a10);
    else pass_cnt++;
    bus.ppu_addr = 14'h2800;
    #1;
    total_cnt++;
    if (ciram_a10 !== 1'b0) $display("FAIL mir_v_2800 got %b exp 0", ciram_a10);
    else pass_cnt++;
    // 32K mode with prg=5: bank = {010, a14}
    rd(15'h0000, 1'b0);
    total_cnt++;
    if (prg_addr !== 17'h10000) $display("FAIL prg32_8000 got %h exp %h", prg_addr, 17'h10000);
    else pass_cnt++;
    rd(15'h4000, 1'b0);
    total_cnt++;
    if (prg_addr !== 17'h14000) $display("FAIL prg32_c000 got %h exp %h", prg_addr, 17'h14000);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_reset_write();
    wr(15'h2000, 8'h01);
    wr(15'h2000, 8'h01);
    wr(15'h2000, 8'h01);
    wr(15'h0000, 8'h80);
    total_cnt++;
    if (ctrl !== 5'h0E) $display("FAIL rstw_ctrl got %h exp %h", ctrl, 5'h0E);
    else pass_cnt++;
    wr5(15'h2000, 5'b00011);
    total_cnt++;
    if (chr0 !== 5'h03) $display("FAIL rstw_chr0 got %h exp %h", chr0, 5'h03);
    else pass_cnt++;
    wr(15'h4000, 8'h01);
    wr(15'h4000, 8'h00);
    wr(15'h4000, 8'h01);
    wr(15'h4000, 8'h00);
    wr(15'h4000, 8'h81);
    total_cnt++;
    if (chr1 !== 5'h00) $display("FAIL rstw_fifth got %h exp %h", chr1, 5'h00);
    else pass_cnt++;
    wr5(15'h4000, 5'b00101);
    total_cnt++;
    if (chr1 !== 5'h05) $display("FAIL rstw_chr1 got %h exp %h", chr1, 5'h05);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.cpu_addr   = 15'h6000;
    bus.cpu_rw     = 1'b0;
    bus.romsel     = 1'b0;
    bus.cpu_data_i = 8'h01;
    tick();
    bus.cpu_data_i = 8'h00;
    tick();
    idle();
    tick();
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h00);
    total_cnt++;
    if (prg !== 5'h05) $display("FAIL b2b_early got %h exp %h", prg, 5'h05);
    else pass_cnt++;
    wr(15'h6000, 8'h00);
    total_cnt++;
    if (prg !== 5'h07) $display("FAIL b2b_prg got %h exp %h", prg, 5'h07);
    else pass_cnt++;
  endtask

  task automatic test_chr();
    wr5(15'h0000, 5'h10);
    total_cnt++;
    if (ctrl !== 5'h10) $display("FAIL chr_ctrl got %h exp %h", ctrl, 5'h10);
    else pass_cnt++;
    bus.ppu_addr = 14'h0123;
    #1;
    total_cnt++;
    if (chr_addr !== 13'h1123) $display("FAIL chr_lo got %h exp %h", chr_addr, 13'h1123);
    else pass_cnt++;
    bus.ppu_addr = 14'h1123;
    #1;
    total_cnt++;
    if (chr_addr !== 13'h1123) $display("FAIL chr_hi got %h exp %h", chr_addr, 13'h1123);
    else pass_cnt++;
    bus.ppu_addr = 14'h0456;
    #1;
    total_cnt++;
    if (chr_addr !== 13'h1456) $display("FAIL chr_456 got %h exp %h", chr_addr, 13'h1456);
    else pass_cnt++;
  endtask

  task automatic test_ram();
    for (int i = 0; i < 4; i++) wr(15'h6000, 8'h00);
    for (int i = 0; i < 3; i++) wr(15'h6000, 8'h01, 1'b1);
    total_cnt++;
    if (prg !== 5'h07) $display("FAIL ram_noshift got %h exp %h", prg, 5'h07);
    else pass_cnt++;
    wr(15'h6000, 8'h01);
    total_cnt++;
    if (prg !== 5'h10) $display("FAIL ram_prg got %h exp %h", prg, 5'h10);
    else pass_cnt++;
    rd(15'h6000, 1'b1);
    total_cnt++;
    if (prg_ram_ce !== 1'b0) $display("FAIL ram_ce_off got %b exp 0", prg_ram_ce);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_rst_mid();
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h01);
    bus.cpu_addr   = 15'h6000;
    bus.cpu_rw     = 1'b0;
    bus.romsel     = 1'b0;
    bus.cpu_data_i = 8'h01;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (ctrl !== 5'h0C || prg !== 5'h00 || chr0 !== 5'h00 || chr1 !== 5'h00)
      $display("FAIL mid_rst got %h/%h/%h/%h exp 0c/00/00/00", ctrl, prg, chr0, chr1);
    else pass_cnt++;
    tick();
    idle();
    tick();
    for (int i = 0; i < 4; i++) wr(15'h6000, 8'h00);
    total_cnt++;
    if (prg !== 5'h01) $display("FAIL mid_first got %h exp %h", prg, 5'h01);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b1;
    bus.cpu_addr = 15'h0;
    bus.ppu_addr = 14'h0;
    idle();
    test_reset();
    test_prg_load();
    test_mirroring();
    test_reset_write();
    test_back_to_back();
    test_chr();
    test_ram();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
